queue_flags: RTL and testbench
==============================

Name: queue_flags

Overview:
- Parametrised successor to the team's single-clock queue.
- Generic data width and depth; optional first-word-fall-through (FWFT) read mode.
- Adds a fill-level output, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags with a clear input.
- Buffers sampled or counter data between producer and consumer logic in board tops, driven by the slow tick clock or directly by CLOCK_50.

Parameters:
- data_width, 8, bits per entry.
- address_width, 4, pointer width; DEPTH = 2^address_width entries.
- afull_level, 14, almost_full asserts when level >= afull_level; legal range 1..DEPTH.
- aempty_level, 2, almost_empty asserts when level <= aempty_level; legal range 0..DEPTH-1.
- fwft, 0, 0 = registered read (one-cycle latency); 1 = head entry always presented on read_data.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset: 0 resets immediately; deassertion is synchronised externally.
- write_cmd  in  1  push request.
- write_data  in  data_width  push data.
- read_cmd  in  1  pop request.
- clear_err  in  1  clears overflow/underflow.
- read_data  out  data_width  popped data (fwft=0) or head entry (fwft=1).
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= afull_level.
- almost_empty  out  1  level <= aempty_level.
- level  out  address_width+1  number of stored entries, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - Write and read pointers 0, level 0, read_data 0, overflow 0, underflow 0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - Stored contents are don't-care.
- Acceptance, evaluated on pre-edge state:
  - rd_ok = read_cmd & ~empty.
  - wr_ok = write_cmd & (~full | read_cmd).
  - A full queue accepts a write only together with a read in the same cycle.
- Empty with read_cmd and write_cmd together: write accepted, read rejected (underflow set), level goes 0 -> 1.
- Full with read_cmd and write_cmd together: both accepted, level stays DEPTH, full stays 1, no overflow.
- Level update: +1 for wr_ok only, -1 for rd_ok only, unchanged for both or neither. Level is registered.
- Flags are combinational decodes of the level register; they change the cycle after the causing edge.
- Pointers are address_width bits and wrap DEPTH-1 -> 0 naturally. No entry is lost or duplicated across the wrap.
- fwft=0:
  - On rd_ok, read_data <= mem[rd_ptr] at the same edge, so it is valid one cycle after read_cmd is sampled.
  - read_data holds its last value otherwise, including on a rejected read.
- fwft=1:
  - read_data = mem[rd_ptr] whenever empty=0; read_cmd advances to the next entry.
  - With empty=1, read_data is the last presented value, or 0 after reset.
  - A write into an empty queue is visible on read_data the cycle after the write edge.
- Errors:
  - overflow is set when write_cmd & ~wr_ok.
  - underflow is set when read_cmd & ~rd_ok.
  - clear_err clears both at the next edge. A new error in the same cycle as clear_err wins, and the flag stays 1.
- Rejected operations change no pointer, level or storage.
- Reset mid-operation discards all contents. The first write after release lands at address 0.

Decomposition:
- Shared package queue_pkg holds DEPTH derivation, the level width function (address_width+1) and legal-range checks for afull_level/aempty_level as elaboration-time assertions.
- One sub-module, queue_ram: simple dual-port storage with a synchronous write, plus a registered read port (fwft=0) or an asynchronous read port (fwft=1).
- Pointers, level and flags stay in queue_flags.

Test Plan:
1. Defaults, hold reset=0 then release -> empty=1, almost_empty=1, level=0, full=0, read_data=0, overflow=underflow=0.
2. Write 0x01..0x10 on 16 consecutive cycles:
   - almost_full=1 from level 14; level=16, full=1.
   - 17th write 0xAA -> overflow=1, level=16.
   - Then 16 reads -> read_data 0x01..0x10 in order, one cycle after each read_cmd; empty=1 at end.
3. Fill to 16, assert read_cmd and write_cmd with 0x77 together for 3 cycles -> level stays 16, full=1, overflow=0, then pops return 0x04..0x10 followed by 0x77 x3.
4. Empty queue:
   - read_cmd -> underflow=1, read_data unchanged.
   - read+write of 0x33 together -> level=1, underflow stays 1.
   - clear_err -> underflow=0 next cycle; clear_err with read_cmd on empty -> underflow remains 1.
5. fwft=1: write 0x5A to empty -> next cycle empty=0, read_data=0x5A with no read_cmd; read_cmd -> empty=1 next cycle; 40 write/read pairs 0..39 -> data in order across pointer wrap.
6. Reach level 7, drop reset=0 between edges -> level=0, empty=1 immediately (asynchronously); after release, write 0x11 then read -> 0x11.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared sizing helpers and flag grouping for the parametrised single-clock queue.
// Legality checks are evaluated at elaboration by the instantiating module.
package queue_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } flags_t;

    function automatic int depth_of(input int address_width);
        return 1 << address_width;
    endfunction

    function automatic int level_width(input int address_width);
        return address_width + 1;
    endfunction

    function automatic bit afull_ok(input int afull_level, input int address_width);
        return (afull_level >= 1) && (afull_level <= depth_of(address_width));
    endfunction

    function automatic bit aempty_ok(input int aempty_level, input int address_width);
        return (aempty_level >= 0) && (aempty_level <= depth_of(address_width) - 1);
    endfunction

endpackage

// File: rtl/queue_ram.sv
// Simple dual-port storage: synchronous write, registered (fwft=0) or asynchronous (fwft=1) read.
// No flow control here; the caller only enables ports for accepted operations.
module queue_ram
    import queue_pkg::*;
#(
    parameter int data_width    = 8,
    parameter int address_width = 4,
    parameter int fwft          = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [address_width-1:0] wr_addr,
    input  logic [data_width-1:0]    wr_dat,
    input  logic                     rd_en,
    input  logic [address_width-1:0] rd_addr,
    output logic [data_width-1:0]    rd_dat
);

    localparam int DEPTH = depth_of(address_width);

    logic [data_width-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
    end

    generate
        if (fwft != 0) begin : g_async_rd
            logic unused_ok;
            assign unused_ok = reset ^ rd_en;
            assign rd_dat    = mem[rd_addr];
        end else begin : g_reg_rd
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)     rd_dat <= '0;
                else if (rd_en) rd_dat <= mem[rd_addr];
            end
        end
    endgenerate

endmodule

// File: rtl/queue_flags.sv
// Single-clock queue with fill level, almost flags and sticky overflow/underflow errors.
// Read data one cycle after read_cmd (fwft=0) or head always presented (fwft=1); full accepts a write only with a read.
module queue_flags
    import queue_pkg::*;
#(
    parameter int data_width    = 8,
    parameter int address_width = 4,
    parameter int afull_level   = 14,
    parameter int aempty_level  = 2,
    parameter int fwft          = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  write_cmd,
    input  logic [data_width-1:0]                 write_data,
    input  logic                                  read_cmd,
    input  logic                                  clear_err,
    output logic [data_width-1:0]                 read_data,
    output logic                                  full,
    output logic                                  empty,
    output logic                                  almost_full,
    output logic                                  almost_empty,
    output logic [level_width(address_width)-1:0] level,
    output logic                                  overflow,
    output logic                                  underflow
);

    localparam int DEPTH = depth_of(address_width);
    localparam int LW    = level_width(address_width);

    if (!afull_ok(afull_level, address_width)) begin : g_bad_afull
        $error("queue_flags: afull_level out of range 1..DEPTH");
    end
    if (!aempty_ok(aempty_level, address_width)) begin : g_bad_aempty
        $error("queue_flags: aempty_level out of range 0..DEPTH-1");
    end

    logic [address_width-1:0] wr_ptr;
    logic [address_width-1:0] rd_ptr;
    logic [LW-1:0]            level_q;
    logic                     rd_ok;
    logic                     wr_ok;
    logic [data_width-1:0]    ram_dat;
    flags_t                   flg;

    always_comb begin
        flg              = '0;
        flg.full         = (level_q == LW'(DEPTH));
        flg.empty        = (level_q == '0);
        flg.almost_full  = (level_q >= LW'(afull_level));
        flg.almost_empty = (level_q <= LW'(aempty_level));
    end

    // A full queue frees a slot in the same cycle it is read, so the write may proceed.
    assign rd_ok = read_cmd & ~flg.empty;
    assign wr_ok = write_cmd & (~flg.full | read_cmd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !rd_ok)      level_q <= level_q + 1'b1;
            else if (rd_ok && !wr_ok) level_q <= level_q - 1'b1;
            overflow  <= (write_cmd & ~wr_ok) | (overflow  & ~clear_err);
            underflow <= (read_cmd  & ~rd_ok) | (underflow & ~clear_err);
        end
    end

    queue_ram #(
        .data_width    (data_width),
        .address_width (address_width),
        .fwft          (fwft)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_dat  (write_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_dat  (ram_dat)
    );

    generate
        if (fwft != 0) begin : g_fwft
            // Keeps the last presented head visible once the queue drains.
            logic [data_width-1:0] hold_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)          hold_q <= '0;
                else if (!flg.empty) hold_q <= ram_dat;
            end
            assign read_data = flg.empty ? hold_q : ram_dat;
        end else begin : g_reg
            assign read_data = ram_dat;
        end
    endgenerate

    assign full         = flg.full;
    assign empty        = flg.empty;
    assign almost_full  = flg.almost_full;
    assign almost_empty = flg.almost_empty;
    assign level        = level_q;

endmodule

// File: tb/tb_queue_flags.sv
// Drives a registered-read and an FWFT queue with identical stimulus; a queue-based model predicts each edge.
module tb_queue_flags;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       wr = 1'b0, rd = 1'b0, clr = 1'b0;
    logic [7:0] wd = 8'h00;

    logic [7:0] rdat0, rdat1;
    logic       full0, empty0, af0, ae0, ov0, un0;
    logic       full1, empty1, af1, ae1, ov1, un1;
    logic [4:0] lvl0, lvl1;

    queue_flags #(.fwft(0)) u_dut0 (
        .clk(clk), .reset(rst_n), .write_cmd(wr), .write_data(wd), .read_cmd(rd),
        .clear_err(clr), .read_data(rdat0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .level(lvl0), .overflow(ov0), .underflow(un0)
    );

    queue_flags #(.fwft(1)) u_dut1 (
        .clk(clk), .reset(rst_n), .write_cmd(wr), .write_data(wd), .read_cmd(rd),
        .clear_err(clr), .read_data(rdat1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .level(lvl1), .overflow(ov1), .underflow(un1)
    );

    typedef struct {
        int         lvl;
        bit         ful, emp, af, ae, ov, un;
        logic [7:0] rd0, rd1;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    bit         rst_want = 1'b0;

    // Reference model: a plain queue of stored bytes plus the observable registers.
    logic [7:0] mq[$];
    bit         m_ov, m_un;
    logic [7:0] m_rd0, m_shown;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_ov    = 1'b0;
        m_un    = 1'b0;
        m_rd0   = 8'h00;
        m_shown = 8'h00;
    endfunction

    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
        exp_t e;
        bit   emp, ful, rok, wok;
        @(negedge clk);
        rst_n = rst_want;
        wr    = w;
        wd    = d;
        rd    = r;
        clr   = c;
        if (!rst_want) begin
            model_reset();
        end else begin
            emp  = (mq.size() == 0);
            ful  = (mq.size() == 16);
            rok  = r && !emp;
            wok  = w && (!ful || r);
            m_ov = (w && !wok) || (m_ov && !c);
            m_un = (r && !rok) || (m_un && !c);
            if (rok) m_rd0 = mq.pop_front();
            if (wok) mq.push_back(d);
            if (mq.size() > 0) m_shown = mq[0];
        end
        e.lvl = mq.size();
        e.ful = (mq.size() == 16);
        e.emp = (mq.size() == 0);
        e.af  = (mq.size() >= 14);
        e.ae  = (mq.size() <= 2);
        e.ov  = m_ov;
        e.un  = m_un;
        e.rd0 = m_rd0;
        e.rd1 = m_shown;
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                automatic exp_t e = exp_q.pop_front();
                chk("level0", 32'(lvl0), 32'(e.lvl));
                chk("full0", 32'(full0), 32'(e.ful));
                chk("empty0", 32'(empty0), 32'(e.emp));
                chk("afull0", 32'(af0), 32'(e.af));
                chk("aempty0", 32'(ae0), 32'(e.ae));
                chk("ovf0", 32'(ov0), 32'(e.ov));
                chk("unf0", 32'(un0), 32'(e.un));
                chk("rdata0", 32'(rdat0), 32'(e.rd0));
                chk("level1", 32'(lvl1), 32'(e.lvl));
                chk("full1", 32'(full1), 32'(e.ful));
                chk("empty1", 32'(empty1), 32'(e.emp));
                chk("afull1", 32'(af1), 32'(e.af));
                chk("aempty1", 32'(ae1), 32'(e.ae));
                chk("ovf1", 32'(ov1), 32'(e.ov));
                chk("unf1", 32'(un1), 32'(e.un));
                chk("rdata1", 32'(rdat1), 32'(e.rd1));
            end
        end
    end

    initial begin
        model_reset();
        // Reset held, then released
        rst_want = 1'b0;
        repeat (3) step(0, 8'h00, 0, 0);
        rst_want = 1'b1;
        step(0, 8'h00, 0, 0);

        // Fill, overflow, drain in order
        for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0);
        step(1, 8'hAA, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);

        // Full with simultaneous read and write
        for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0);
        repeat (3) step(1, 8'h77, 1, 0);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);

        // Underflow handling on an empty queue
        step(0, 8'h00, 1, 0);
        step(1, 8'h33, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 1, 1);
        step(0, 8'h00, 0, 1);

        // Head presentation and pointer wrap
        step(1, 8'h5A, 0, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 1, 0);
        for (int i = 0; i < 40; i++) begin
            step(1, 8'(i), 0, 0);
            step(0, 8'h00, 1, 0);
        end

        // Asynchronous reset between edges
        for (int i = 0; i < 7; i++) step(1, 8'(8'h20 + i), 0, 0);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        rst_want = 1'b0;
        model_reset();
        #1;
        chk("async_level0", 32'(lvl0), 32'd0);
        chk("async_empty0", 32'(empty0), 32'd1);
        chk("async_level1", 32'(lvl1), 32'd0);
        chk("async_empty1", 32'(empty1), 32'd1);
        step(0, 8'h00, 0, 0);
        rst_want = 1'b1;
        step(1, 8'h11, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // Randomised traffic in three fill-bias phases with rare resets
        for (int ph = 0; ph < 3; ph++) begin
            for (int n = 0; n < 500; n++) begin
                automatic int  wp = (ph == 0) ? 70 : (ph == 1) ? 50 : 30;
                automatic bit  w  = ($urandom_range(0, 99) < wp);
                automatic bit  r  = ($urandom_range(0, 99) < (100 - wp));
                automatic bit  c  = ($urandom_range(0, 99) < 5);
                rst_want = ($urandom_range(0, 299) != 0);
                step(w, 8'($urandom), r, c);
            end
        end
        rst_want = 1'b1;
        step(0, 8'h00, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
